// File: rtl/serial_sequence_detector.sv
// Frame-marker detector: watches sin for 0111110, pulses wake_nbit on a match,
// then holds wake_transmitter until the transmitter reports completion.
module serial_sequence_detector (
    input  logic clk,
    input  logic rst,
    input  logic sin,
    input  logic gb,
    input  logic transmitter_signal,
    output logic wake_nbit,
    output logic wake_transmitter
);

    typedef enum logic [3:0] {
        IDLE,
        S0,
        S01,
        S011,
        S0111,
        S01111,
        S011111,
        DETECT,
        TRANSMIT
    } state_t;

    state_t state_reg;
    state_t state_next;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            DETECT:   state_next = TRANSMIT;
            TRANSMIT: state_next = transmitter_signal ? IDLE : TRANSMIT;
            default: begin
                if (!gb) begin
                    state_next = IDLE;
                end else begin
                    // A 0 part-way through the ones may begin a fresh marker.
                    case (state_reg)
                        IDLE:    state_next = sin ? IDLE    : S0;
                        S0:      state_next = sin ? S01     : S0;
                        S01:     state_next = sin ? S011    : S0;
                        S011:    state_next = sin ? S0111   : S0;
                        S0111:   state_next = sin ? S01111  : S0;
                        S01111:  state_next = sin ? S011111 : S0;
                        S011111: state_next = sin ? IDLE    : DETECT;
                        default: state_next = IDLE;
                    endcase
                end
            end
        endcase
    end

    // Outputs are registered from the next state so they track the state bit-for-bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg        <= IDLE;
            wake_nbit        <= 1'b0;
            wake_transmitter <= 1'b0;
        end else begin
            state_reg        <= state_next;
            wake_nbit        <= (state_next == DETECT);
            wake_transmitter <= (state_next == TRANSMIT);
        end
    end

endmodule

// File: tb/tb_serial_sequence_detector.sv
// Scoreboard bench for serial_sequence_detector: the driver queues the expected
// outputs for each sampled bit and a monitor compares them after every edge.
module tb_serial_sequence_detector;

    logic clk = 1'b0;
    logic rst;
    logic sin;
    logic gb;
    logic transmitter_signal;
    logic wake_nbit;
    logic wake_transmitter;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic  nbit;
        logic  tx;
        string tag;
    } exp_t;

    exp_t exp_q[$];

    serial_sequence_detector dut (
        .clk                (clk),
        .rst                (rst),
        .sin                (sin),
        .gb                 (gb),
        .transmitter_signal (transmitter_signal),
        .wake_nbit          (wake_nbit),
        .wake_transmitter   (wake_transmitter)
    );

    always #5 clk = ~clk;

    // Inputs change on the falling edge; the expectation is for the next rising edge.
    task automatic step(input logic s, input logic g, input logic t,
                        input logic en, input logic et, input string tag);
        exp_t e;
        @(negedge clk);
        sin = s;
        gb = g;
        transmitter_signal = t;
        e.nbit = en;
        e.tx = et;
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    // Feed a bit string MSB-first (first-received bit first); wake_nbit expected only on the last bit if det.
    task automatic feed(input logic [15:0] bits, input int n, input logic g,
                        input logic det, input string tag);
        for (int i = n - 1; i >= 0; i--)
            step(bits[i], g, 1'b0, (det && i == 0), 1'b0, tag);
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 50) begin
            @(posedge clk);
            budget++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d entries left, required 0", exp_q.size());
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        #2;
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (wake_nbit !== e.nbit || wake_transmitter !== e.tx) begin
                errors++;
                $display("FAIL %s cyc%0d: got nbit=%b tx=%b, required nbit=%b tx=%b",
                         e.tag, cyc, wake_nbit, wake_transmitter, e.nbit, e.tx);
            end else begin
                $display("cyc%0d %s: nbit=%b tx=%b ok", cyc, e.tag, wake_nbit, wake_transmitter);
            end
        end
    end

    initial begin
        rst = 1'b0;
        sin = 1'b0;
        gb = 1'b0;
        transmitter_signal = 1'b0;
        #3;
        checks++;
        if (wake_nbit !== 1'b0 || wake_transmitter !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got nbit=%b tx=%b, required 0 0", wake_nbit, wake_transmitter);
        end
        @(negedge clk);
        rst = 1'b1;

        // Enable off: marker ignored
        feed(16'b0111110, 7, 1'b0, 1'b0, "enable_off");

        // Basic match with a leading 1
        feed(16'b10111110, 8, 1'b1, 1'b1, "basic_match");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "detect_ignores_inputs");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "transmit_hold");
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "transmit_hold");
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "transmit_release");

        // Partial restart: 0 after 011 returns to S0
        feed(16'b0110111110, 10, 1'b1, 1'b1, "partial_restart");
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "transmit_hold");
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "transmit_release");

        // Six ones reject; then five ones without a leading 0 from IDLE
        feed(16'b01111110, 8, 1'b1, 1'b0, "six_ones");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "gb_clear");
        feed(16'b111110, 6, 1'b1, 1'b0, "no_leading_zero");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "gb_clear");

        // gb drop mid-search aborts the partial match
        feed(16'b0111, 4, 1'b1, 1'b0, "gb_abort_pre");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "gb_abort");
        feed(16'b110, 3, 1'b1, 1'b0, "gb_abort_post");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "gb_clear");

        // Reset in the middle of TRANSMIT drops the output without a clock edge
        feed(16'b0111110, 7, 1'b1, 1'b1, "pre_reset_match");
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "pre_reset_transmit");
        drain();
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (wake_nbit !== 1'b0 || wake_transmitter !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got nbit=%b tx=%b, required 0 0", wake_nbit, wake_transmitter);
        end else begin
            $display("async_reset: outputs dropped ok");
        end
        @(negedge clk);
        rst = 1'b1;
        feed(16'b0111110, 7, 1'b1, 1'b1, "post_reset_match");
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "transmit_hold");
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "transmit_release");

        // Detection again straight after a release
        feed(16'b0111110, 7, 1'b1, 1'b1, "post_release_match");
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, "detect_ignores_ts");
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "transmit_release");
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "idle_after_release");

        drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
